// File: rtl/pipe_fifo32_pkg.sv
// Shared defaults and width/pointer helpers for the pipe_fifo32 pipeline FIFO.
package pipe_fifo32_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int FIFO_WIDTH_DEFAULT = 32;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full FIFO (count == depth) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_fifo32_if.sv
// Producer/consumer handshake bundle for pipe_fifo32; slave is the FIFO side.
interface pipe_fifo32_if
    import pipe_fifo32_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) ();

    logic                          flush;
    logic                          in_valid;
    logic [WIDTH-1:0]              in_data;
    logic                          in_ready;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_data;
    logic                          out_ready;
    logic [count_width(DEPTH)-1:0] count;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/reg32_en_sync.sv
// W-bit register with synchronous clear and write enable; clear wins over enable.
module reg32_en_sync #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (srst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_fifo32.sv
// Register-based synchronous FIFO between pipeline stages, with flush for redirects.
module pipe_fifo32
    import pipe_fifo32_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    pipe_fifo32_if.slave   bus
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic             clear;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rd_chain [DEPTH+1];

    // Status is decoded from registered count only, so no input reaches an output.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign clear = reset | bus.flush;
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    assign wr_ptr_next = PTR_W'(ptr_inc(int'(wr_ptr_reg), DEPTH));
    assign rd_ptr_next = PTR_W'(ptr_inc(int'(rd_ptr_reg), DEPTH));
    assign count_next  = push ? count_reg + CNT_W'(1) : count_reg - CNT_W'(1);

    reg32_en_sync #(.W(PTR_W)) u_wr_ptr (
        .clk(clk), .srst(clear), .en(push), .d(wr_ptr_next), .q(wr_ptr_reg)
    );

    reg32_en_sync #(.W(PTR_W)) u_rd_ptr (
        .clk(clk), .srst(clear), .en(pop), .d(rd_ptr_next), .q(rd_ptr_reg)
    );

    // Simultaneous push and pop leave the count unchanged.
    reg32_en_sync #(.W(CNT_W)) u_count (
        .clk(clk), .srst(clear), .en(push ^ pop), .d(count_next), .q(count_reg)
    );

    assign rd_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wr_en;
            logic rd_sel;

            // A flush/reset cycle must not write storage, hence the ~clear term.
            assign wr_en  = push & ~clear & (wr_ptr_reg == PTR_W'(gi));
            assign rd_sel = (rd_ptr_reg == PTR_W'(gi));

            reg32_en_sync #(.W(WIDTH)) u_mem (
                .clk(clk), .srst(1'b0), .en(wr_en), .d(bus.in_data), .q(mem_reg[gi])
            );

            assign rd_chain[gi+1] = rd_chain[gi] | (mem_reg[gi] & {WIDTH{rd_sel}});
        end
    endgenerate

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_data  = rd_chain[DEPTH];
    assign bus.count     = count_reg;

endmodule

// File: tb/tb_pipe_fifo32.sv
// Directed bench for pipe_fifo32 with a queue scoreboard checked after every edge.
module tb_pipe_fifo32;
    import pipe_fifo32_pkg::*;

    localparam int W = 32;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] model_q [$];

    pipe_fifo32_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pipe_fifo32 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge, update the model, check after the rising edge.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [W-1:0] id, input logic ordy);
        logic acc_push;
        logic acc_pop;
        reset         = rst;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        acc_push = iv && (model_q.size() < D);
        acc_pop  = ordy && (model_q.size() > 0);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            if (acc_pop) void'(model_q.pop_front());
            if (acc_push) model_q.push_back(id);
        end
        @(posedge clk);
        #1;
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < D));
        check("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check("out_data", bus.out_data, model_q[0]);
        end
        $display("t=%0t rst=%0b fl=%0b iv=%0b id=%h ordy=%0b -> count=%0d ov=%0b od=%h",
                 $time, rst, fl, iv, id, ordy, bus.count, bus.out_valid, bus.out_data);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Fill to full, then attempt a refused fifth push.
        step(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0);

        // Full with push and pop offered: pop only.
        step(1'b0, 1'b0, 1'b1, 32'h66666666, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Streaming from empty: first cycle is push only, then count holds at 1.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with a concurrent push and pop.
        step(1'b0, 1'b0, 1'b1, 32'hA0000001, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hA0000002, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hA0000003, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with count=2.
        step(1'b0, 1'b0, 1'b1, 32'hB0000001, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hB0000002, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hB0000003, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hC0000001, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hC0000002, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_fifo32.md
# pipe_fifo32

Synchronous FIFO queue (default 4 entries × 32 bits) that decouples two adjacent pipeline stages built from the basic gate library. A producer stage pushes words and a consumer stage pops them, both using valid/ready handshakes. Occupancy is exposed for stall logic. The FIFO has a synchronous flush for pipeline redirects such as branch mispredicts and exceptions.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 4, number of entries; power of two, 2..16
- PTR_W, log2(DEPTH), pointer width in bits; derived, not overridden

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  producer offers in_data this cycle
- in_data  input  WIDTH  word to enqueue
- in_ready  output  1  FIFO can accept a word this cycle
- out_valid  output  1  out_data holds the oldest entry
- out_data  output  WIDTH  oldest entry, at rd_ptr
- out_ready  input  1  consumer takes out_data this cycle
- count  output  PTR_W+1  current number of entries, 0..DEPTH

## Operation
- Push: occurs when in_valid & in_ready. Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- Pop: occurs when out_valid & out_ready. Increments rd_ptr modulo DEPTH.
- in_ready = (count != DEPTH).
  - A full FIFO rejects a push even if a pop happens in the same cycle; there is no full-bypass.
- out_valid = (count != 0).
  - There is no empty-bypass: a word pushed into an empty FIFO is visible on the next cycle.
- Count update on each edge:
  - push only: count+1
  - pop only: count−1
  - push and pop together: count unchanged; both pointers advance
- Pointers wrap naturally: from DEPTH−1 to 0.
- Priority, highest first: reset, then flush, then push/pop.
  - reset or flush: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop in that cycle is discarded; storage is not written.
- Storage array is not reset.
  - out_data is don't-care while out_valid=0. The bench checks out_data only when out_valid=1.
- The producer may drop in_valid without a handshake. The consumer may drop out_ready at any time. Neither is an error.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, count=0.
  - out_data is undefined (storage not reset).
- Latency: push-to-visible is 1 cycle. A word pushed at edge N appears on out_data with out_valid=1 after edge N.
- Throughput: 1 push and 1 pop per cycle, sustained whenever 0 < count < DEPTH.
- in_ready, out_valid and count are decoded from registered state only.
  - No combinational path from in_valid, out_ready or flush to any output.
- out_data is a read mux of mem[rd_ptr]. It is driven from registers only and changes only after an edge.
- Reset or flush asserted mid-stream takes effect at that edge. The next cycle shows empty state regardless of traffic in the flush cycle.
- Boundaries:
  - Full, with in_valid & out_ready: pop only; count goes DEPTH→DEPTH−1.
  - Empty, with in_valid & out_ready: push only; count goes 0→1.

## Structure
- Shared package holds:
  - FIFO_DEPTH_DEFAULT=4
  - FIFO_WIDTH_DEFAULT=32
  - a pointer-increment-with-wrap constant function
  - the count width derivation
- Natural sub-module: `reg32_en_sync`, a WIDTH-bit register with write enable.
  - One instance per storage entry. The write enable is the decoded (wr_ptr==i) & push.
  - Pointer and count registers reuse the same sub-module at their narrow width.
- Full/empty decode and the read mux are built from existing gate-library components: N-way AND/OR gates, inverters and 32-bit AND/OR.

## Test plan
- Reset, then idle: count=0, in_ready=1, out_valid=0 for 5 cycles. in_valid=0 throughout.
- Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_ready=0:
  - count steps 1,2,3,4; in_ready=0 after the 4th push.
  - A 5th push of 0x55555555 is refused and count stays 4.
- From full, hold out_ready=1 and in_valid=0: out_data sequence is 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with data = cycle index.
  - count holds at 1 after the first cycle.
  - Outputs match inputs delayed by exactly 1 cycle.
  - Pointers wrap at least 4 times.
- Load 3 entries, then assert flush together with a push of 0xDEADBEEF and out_ready=1:
  - Next cycle: count=0, out_valid=0.
  - Following push of 0xCAFEF00D appears as the first output.
- Assert reset for one cycle while count=2 and push/pop are active: next cycle shows reset values, and later pops never return pre-reset data.
